// File: rtl/isqrt_pipe_with_valid.sv
// Pipelined restoring integer square root, one root bit per stage; optional remainder port via ISQRT_PIPE_REM_EN.
// Latency: n/2 cycles from x_vld to y_vld, one operand accepted per cycle.
// No backpressure: valid shifts every cycle, data registers load only behind a valid.
module isqrt_pipe_with_valid #(
    parameter int n = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_vld,
    input  logic [n-1:0]     x,
    output logic             y_vld,
`ifdef ISQRT_PIPE_REM_EN
    output logic [n/2:0]     r,
`endif
    output logic [n/2-1:0]   y
);

    localparam int stages = n / 2;
    localparam int hw     = n / 2;
    localparam int rw     = n / 2 + 2;

    logic          vld_in  [stages];
    logic [n-1:0]  op_in   [stages];
    logic [hw-1:0] root_in [stages];
    logic [rw-1:0] rem_in  [stages];

    logic [n-1:0]  op_nx   [stages];
    logic [hw-1:0] root_nx [stages];
    logic [rw-1:0] rem_nx  [stages];

    logic          vld_q   [stages];
    logic [n-1:0]  op_q    [stages];
    logic [hw-1:0] root_q  [stages];
    logic [rw-1:0] rem_q   [stages];

    for (genvar k = 0; k < stages; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign vld_in[k]  = x_vld;
            assign op_in[k]   = x;
            assign root_in[k] = '0;
            assign rem_in[k]  = '0;
        end else begin : g_next
            assign vld_in[k]  = vld_q[k-1];
            assign op_in[k]   = op_q[k-1];
            assign root_in[k] = root_q[k-1];
            assign rem_in[k]  = rem_q[k-1];
        end

        logic [rw-1:0] rem_sh;
        logic [rw-1:0] trial;
        logic          ge;
        // Remainder stays below 2*root+1, so its top two bits are always zero here.
        logic          unused_rem_top;

        assign rem_sh         = {rem_in[k][hw-1:0], op_in[k][n-1:n-2]};
        assign trial          = {root_in[k], 2'b01};
        assign ge             = (rem_sh >= trial);
        assign rem_nx[k]      = ge ? (rem_sh - trial) : rem_sh;
        assign root_nx[k]     = {root_in[k][hw-2:0], ge};
        assign op_nx[k]       = {op_in[k][n-3:0], 2'b00};
        assign unused_rem_top = ^rem_in[k][rw-1:hw];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < stages; k++) begin
                vld_q[k]  <= 1'b0;
                op_q[k]   <= '0;
                root_q[k] <= '0;
                rem_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < stages; k++) begin
                vld_q[k] <= vld_in[k];
                if (vld_in[k]) begin
                    op_q[k]   <= op_nx[k];
                    root_q[k] <= root_nx[k];
                    rem_q[k]  <= rem_nx[k];
                end
            end
        end
    end

    assign y_vld = vld_q[stages-1];
    assign y     = root_q[stages-1];

    logic unused_op_tail;
    assign unused_op_tail = ^op_q[stages-1];

`ifdef ISQRT_PIPE_REM_EN
    logic unused_rem_msb;
    assign r              = rem_q[stages-1][hw:0];
    assign unused_rem_msb = rem_q[stages-1][rw-1];
`else
    logic unused_rem_out;
    assign unused_rem_out = ^rem_q[stages-1];
`endif

endmodule

// File: tb/tb_isqrt_pipe_with_valid.sv
// Directed bench for isqrt_pipe_with_valid (n=32): hand-computed roots carried alongside each operand.
module tb_isqrt_pipe_with_valid;

    localparam int N  = 32;
    localparam int ST = N / 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              x_vld;
    logic [N-1:0]      x;
    logic              y_vld;
    logic [N/2-1:0]    y;
`ifdef ISQRT_PIPE_REM_EN
    logic [N/2:0]      r;
`endif

    isqrt_pipe_with_valid #(.n(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .x_vld (x_vld),
        .x     (x),
        .y_vld (y_vld),
`ifdef ISQRT_PIPE_REM_EN
        .r     (r),
`endif
        .y     (y)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    string tag;
    bit hold_chk;

    // Expected contents of each stage, shifted once per clock edge.
    logic           m_vld [ST];
    logic [N/2-1:0] m_y   [ST];
    logic [N/2:0]   m_r   [ST];
    logic [N/2-1:0] last_y;
    logic [N/2:0]   last_r;

    function automatic logic [N/2-1:0] ref_sqrt(input logic [N-1:0] v);
        logic [63:0] t;
        logic [N/2-1:0] res;
        res = '0;
        for (int b = N/2-1; b >= 0; b--) begin
            t = 64'(res | (16'(1) << b));
            if (t * t <= 64'(v)) res = res | (16'(1) << b);
        end
        return res;
    endfunction

    task automatic chk_vld(input logic exp);
        checks++;
        assert (y_vld === exp) else begin
            errors++;
            $error("FAIL %s y_vld got %0b want %0b", tag, y_vld, exp);
        end
    endtask

    task automatic chk_y(input logic [N/2-1:0] exp);
        checks++;
        assert (y === exp) else begin
            errors++;
            $error("FAIL %s y got %0d want %0d", tag, y, exp);
        end
    endtask

`ifdef ISQRT_PIPE_REM_EN
    task automatic chk_r(input logic [N/2:0] exp);
        checks++;
        assert (r === exp) else begin
            errors++;
            $error("FAIL %s r got %0d want %0d", tag, r, exp);
        end
    endtask
`endif

    // Drive one cycle of inputs, clock it, then compare outputs against the expected pipe.
    task automatic tick(input logic rs, input logic v, input logic [N-1:0] xv,
                        input logic [N/2-1:0] ey, input logic [N/2:0] er);
        rst   = rs;
        x_vld = v;
        x     = xv;
        @(posedge clk);
        for (int k = ST-1; k > 0; k--) begin
            m_vld[k] = m_vld[k-1];
            m_y[k]   = m_y[k-1];
            m_r[k]   = m_r[k-1];
        end
        m_vld[0] = v & ~rs;
        m_y[0]   = ey;
        m_r[0]   = er;
        if (rs) begin
            for (int k = 0; k < ST; k++) begin
                m_vld[k] = 1'b0;
                m_y[k]   = '0;
                m_r[k]   = '0;
            end
            last_y = '0;
            last_r = '0;
        end
        #1;
        chk_vld(m_vld[ST-1]);
        if (m_vld[ST-1]) begin
            last_y = m_y[ST-1];
            last_r = m_r[ST-1];
            chk_y(last_y);
`ifdef ISQRT_PIPE_REM_EN
            chk_r(last_r);
`endif
        end else if (hold_chk) begin
            chk_y(last_y);
`ifdef ISQRT_PIPE_REM_EN
            chk_r(last_r);
`endif
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        logic [N-1:0] rv;
        logic [N/2-1:0] ry;
        rst = 1'b1; x_vld = 1'b0; x = '0;
        hold_chk = 1'b1;
        last_y = '0; last_r = '0;
        for (int k = 0; k < ST; k++) begin
            m_vld[k] = 1'b0; m_y[k] = '0; m_r[k] = '0;
        end

        tag = "reset";
        tick(1'b1, 1'b0, '0, '0, '0);
        tick(1'b1, 1'b0, '0, '0, '0);
        idle(2);

        tag = "small";
        tick(1'b0, 1'b1, 32'd0,  16'd0, 17'd0);
        tick(1'b0, 1'b1, 32'd1,  16'd1, 17'd0);
        tick(1'b0, 1'b1, 32'd15, 16'd3, 17'd6);
        tick(1'b0, 1'b1, 32'd16, 16'd4, 17'd0);
        idle(20);

        tag = "max";
        tick(1'b0, 1'b1, 32'hFFFF_FFFF, 16'hFFFF, 17'd131070);
        idle(20);

        tag = "random";
        hold_chk = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rv = $urandom;
            if (i == 0) rv = 32'hFFFE_0001;
            ry = ref_sqrt(rv);
            tick(1'b0, 1'b1, rv, ry, 17'(64'(rv) - 64'(ry) * 64'(ry)));
        end
        idle(20);

        tag = "bubbles";
        hold_chk = 1'b1;
        tick(1'b0, 1'b1, 32'd100,  16'd10, 17'd0);
        tick(1'b0, 1'b0, 32'd5,    16'd0,  17'd0);
        tick(1'b0, 1'b0, 32'd7,    16'd0,  17'd0);
        tick(1'b0, 1'b1, 32'd81,   16'd9,  17'd0);
        tick(1'b0, 1'b1, 32'd4096, 16'd64, 17'd0);
        tick(1'b0, 1'b0, 32'd9,    16'd0,  17'd0);
        tick(1'b0, 1'b1, 32'd2,    16'd1,  17'd1);
        idle(20);

        tag = "midreset";
        tick(1'b0, 1'b1, 32'd4,  16'd2, 17'd0);
        tick(1'b0, 1'b1, 32'd9,  16'd3, 17'd0);
        tick(1'b0, 1'b1, 32'd25, 16'd5, 17'd0);
        tick(1'b0, 1'b1, 32'd36, 16'd6, 17'd0);
        tick(1'b0, 1'b1, 32'd64, 16'd8, 17'd0);
        tick(1'b1, 1'b0, '0, '0, '0);
        tick(1'b0, 1'b1, 32'd49, 16'd7, 17'd0);
        idle(20);

        tag = "rst_vld";
        tick(1'b1, 1'b1, 32'd1000, 16'd31, 17'd39);
        tick(1'b1, 1'b1, 32'd1000, 16'd31, 17'd39);
        tick(1'b1, 1'b1, 32'd1000, 16'd31, 17'd39);
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
